// File: rtl/game_state_ctrl_pkg.sv
// Shared game-state encoding used by the controller and every renderer that
// consumes game_state.
package game_state_ctrl_pkg;

   typedef enum logic [1:0] {
      START_SCREEN = 2'd0,
      PLAYING      = 2'd1,
      GAME_OVER    = 2'd2,
      COUNTDOWN    = 2'd3
   } game_state_t;

   // Plain-vector copies for renderers that compare against a logic [1:0] bus
   localparam logic [1:0] GS_START_SCREEN = 2'd0;
   localparam logic [1:0] GS_PLAYING      = 2'd1;
   localparam logic [1:0] GS_GAME_OVER    = 2'd2;
   localparam logic [1:0] GS_COUNTDOWN    = 2'd3;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/game_state_ctrl_button_debouncer.sv
// Synchronises a raw button, debounces it on frame boundaries and emits the
// debounced level plus a one-cycle rising-edge pulse.
module button_debouncer
   import game_state_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_FRAMES = 2
) (
   input  logic pixel_clk,
   input  logic rst,
   input  logic fsync,
   input  logic btn_raw,
   output logic level,
   output logic rise
);

   localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_FRAMES - 1);

   logic             sync1_q, sync2_q;
   logic             btn_sync;
   logic             level_q, level_d;
   logic             rise_q, rise_d;
   logic [CNT_W-1:0] stable_cnt_q, stable_cnt_d;

   assign btn_sync = sync2_q;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      level_d      = level_q;
      stable_cnt_d = stable_cnt_q;
      rise_d       = 1'b0;
      if (fsync) begin
         if (btn_sync != level_q) begin
            if (stable_cnt_q == CNT_LAST) begin
               level_d      = btn_sync;
               stable_cnt_d = '0;
               rise_d       = btn_sync;
            end else begin
               stable_cnt_d = stable_cnt_q + 1'b1;
            end
         end else begin
            stable_cnt_d = '0;
         end
      end
   end

   always_ff @(posedge pixel_clk) begin
      // NOTE: sequential state uses non-blocking assignments only; the synchronizer flops
      // are reset as well so a button held through reset cannot produce a spurious edge.
      if (rst) begin
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         level_q      <= 1'b0;
         rise_q       <= 1'b0;
         stable_cnt_q <= '0;
      end else begin
         sync1_q      <= btn_raw;
         sync2_q      <= sync1_q;
         level_q      <= level_d;
         rise_q       <= rise_d;
         stable_cnt_q <= stable_cnt_d;
      end
   end

   assign level = level_q;
   assign rise  = rise_q;

endmodule

// File: rtl/game_state_ctrl.sv
// Game sequencer: START_SCREEN -> COUNTDOWN -> PLAYING -> GAME_OVER, timed in
// frames and advanced by armed, debounced fire-button presses.
module game_state_ctrl
   import game_state_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_FRAMES      = 2,
   parameter int COUNTDOWN_FRAMES     = 60,
   parameter int GAMEOVER_HOLD_FRAMES = 120
) (
   input  logic       pixel_clk,
   input  logic       rst,
   input  logic       fsync,
   input  logic       btn_fire_raw,
   input  logic       player_dead,
   output logic [1:0] game_state,
   output logic [1:0] countdown_digit,
   output logic       game_start,
   output logic       btn_pressed
);

   localparam int FRAME_W = $clog2(max_int(COUNTDOWN_FRAMES, GAMEOVER_HOLD_FRAMES) + 1);
   localparam logic [FRAME_W-1:0] CD_LAST  = FRAME_W'(COUNTDOWN_FRAMES - 1);
   localparam logic [FRAME_W-1:0] HOLD_MAX = FRAME_W'(GAMEOVER_HOLD_FRAMES);

   game_state_t        state_q, state_d;
   logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
   logic [1:0]         digit_q, digit_d;
   logic               game_start_q, game_start_d;
   logic               armed_q, armed_d;
   logic               btn_level, btn_rise;

   button_debouncer #(
      .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
   ) u_fire_debouncer (
      .pixel_clk(pixel_clk),
      .rst      (rst),
      .fsync    (fsync),
      .btn_raw  (btn_fire_raw),
      .level    (btn_level),
      .rise     (btn_rise)
   );

   always_comb begin
      state_d      = state_q;
      frame_cnt_d  = frame_cnt_q;
      digit_d      = digit_q;
      game_start_d = 1'b0;
      case (state_q)
         START_SCREEN: begin
            if (btn_rise && armed_q) begin
               state_d     = COUNTDOWN;
               frame_cnt_d = '0;
               digit_d     = 2'd3;
            end
         end
         COUNTDOWN: begin
            if (fsync) begin
               if (frame_cnt_q == CD_LAST) begin
                  frame_cnt_d = '0;
                  if (digit_q == 2'd1) begin
                     state_d      = PLAYING;
                     digit_d      = 2'd0;
                     game_start_d = 1'b1;
                  end else begin
                     digit_d = digit_q - 2'd1;
                  end
               end else begin
                  frame_cnt_d = frame_cnt_q + 1'b1;
               end
            end
         end
         PLAYING: begin
            if (player_dead) begin
               state_d     = GAME_OVER;
               frame_cnt_d = '0;
            end
         end
         GAME_OVER: begin
            // Presses before the hold expires are simply dropped, never queued
            if (fsync && (frame_cnt_q != HOLD_MAX)) begin
               frame_cnt_d = frame_cnt_q + 1'b1;
            end
            if ((frame_cnt_q == HOLD_MAX) && btn_rise && armed_q) begin
               state_d     = START_SCREEN;
               frame_cnt_d = '0;
            end
         end
         default: state_d = START_SCREEN;
      endcase

      // A press only counts once the button has been seen released in the current state
      if (state_d != state_q) begin
         armed_d = 1'b0;
      end else if (!btn_level) begin
         armed_d = 1'b1;
      end else begin
         armed_d = armed_q;
      end
   end

   always_ff @(posedge pixel_clk) begin
      if (rst) begin
         state_q      <= START_SCREEN;
         frame_cnt_q  <= '0;
         digit_q      <= 2'd0;
         game_start_q <= 1'b0;
         armed_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         frame_cnt_q  <= frame_cnt_d;
         digit_q      <= digit_d;
         game_start_q <= game_start_d;
         armed_q      <= armed_d;
      end
   end

   assign game_state      = state_q;
   assign countdown_digit = digit_q;
   assign game_start      = game_start_q;
   assign btn_pressed     = btn_rise;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Scoreboard bench for game_state_ctrl: stimulus queues expected output events,
// a monitor pops and compares each event the DUT presents.
module tb_game_state_ctrl;
   import game_state_ctrl_pkg::*;

   localparam int DF        = 2;
   localparam int CF        = 4;
   localparam int GH        = 120;
   localparam int FRAME_CYC = 8;

   logic       pixel_clk = 1'b0;
   logic       rst;
   logic       fsync = 1'b0;
   logic       btn_fire_raw;
   logic       player_dead;
   logic [1:0] game_state;
   logic [1:0] countdown_digit;
   logic       game_start;
   logic       btn_pressed;

   typedef struct {
      logic [1:0] st;
      logic [1:0] dig;
      logic       gs;
      logic       bp;
      int         gap;   // required cycles since previous event, -1 = any
   } ev_t;

   ev_t  exp_q[$];
   int   errors = 0;
   int   checks = 0;
   logic mon_en = 1'b0;

   game_state_ctrl #(
      .DEBOUNCE_FRAMES     (DF),
      .COUNTDOWN_FRAMES    (CF),
      .GAMEOVER_HOLD_FRAMES(GH)
   ) dut (
      .pixel_clk      (pixel_clk),
      .rst            (rst),
      .fsync          (fsync),
      .btn_fire_raw   (btn_fire_raw),
      .player_dead    (player_dead),
      .game_state     (game_state),
      .countdown_digit(countdown_digit),
      .game_start     (game_start),
      .btn_pressed    (btn_pressed)
   );

   always #5 pixel_clk = ~pixel_clk;

   // One-cycle frame pulse every FRAME_CYC clocks, changed on falling edges
   initial begin
      forever begin
         repeat (FRAME_CYC - 1) @(negedge pixel_clk);
         fsync = 1'b1;
         @(negedge pixel_clk);
         fsync = 1'b0;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic push(input logic [1:0] st, input logic [1:0] dig, input logic gs,
                       input logic bp, input int gap);
      exp_q.push_back('{st: st, dig: dig, gs: gs, bp: bp, gap: gap});
   endtask

   task automatic next_frame();
      do @(posedge pixel_clk); while (fsync !== 1'b1);
      @(negedge pixel_clk);
   endtask

   task automatic frames(input int n);
      repeat (n) next_frame();
   endtask

   task automatic pulse_dead();
      player_dead = 1'b1;
      @(negedge pixel_clk);
      player_dead = 1'b0;
   endtask

   task automatic wait_state(input string name, input logic [1:0] st, input int max_frames);
      int n = 0;
      while (game_state !== st && n < max_frames * FRAME_CYC) begin
         @(negedge pixel_clk);
         n++;
      end
      check(name, {30'b0, game_state}, {30'b0, st});
   endtask

   task automatic wait_digit(input string name, input logic [1:0] dig, input int max_frames);
      int n = 0;
      while (countdown_digit !== dig && n < max_frames * FRAME_CYC) begin
         @(negedge pixel_clk);
         n++;
      end
      check(name, {30'b0, countdown_digit}, {30'b0, dig});
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_state"}, {30'b0, game_state}, 32'd0);
      check({tag, "_digit"}, {30'b0, countdown_digit}, 32'd0);
      check({tag, "_game_start"}, {31'b0, game_start}, 32'd0);
      check({tag, "_btn_pressed"}, {31'b0, btn_pressed}, 32'd0);
   endtask

   // Monitor: any press pulse, start pulse or state/digit change is an event
   initial begin
      logic [1:0] prev_st, prev_dig;
      int         since;
      ev_t        e;
      wait (mon_en);
      prev_st  = game_state;
      prev_dig = countdown_digit;
      since    = 0;
      forever begin
         @(negedge pixel_clk);
         since++;
         if (btn_pressed || game_start || game_state != prev_st || countdown_digit != prev_dig) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_event: got st=%0d dig=%0d gs=%0b bp=%0b, required no event",
                        game_state, countdown_digit, game_start, btn_pressed);
            end else begin
               e = exp_q.pop_front();
               if (game_state !== e.st || countdown_digit !== e.dig || game_start !== e.gs ||
                   btn_pressed !== e.bp || (e.gap >= 0 && since != e.gap)) begin
                  errors++;
                  $display("FAIL event: got st=%0d dig=%0d gs=%0b bp=%0b gap=%0d, required st=%0d dig=%0d gs=%0b bp=%0b gap=%0d",
                           game_state, countdown_digit, game_start, btn_pressed, since,
                           e.st, e.dig, e.gs, e.bp, e.gap);
               end
            end
            prev_st  = game_state;
            prev_dig = countdown_digit;
            since    = 0;
         end
      end
   end

   task automatic expect_start_sequence();
      push(GS_START_SCREEN, 2'd0, 1'b0, 1'b1, -1);
      push(GS_COUNTDOWN,    2'd3, 1'b0, 1'b0, 1);
      push(GS_COUNTDOWN,    2'd2, 1'b0, 1'b0, -1);
      push(GS_COUNTDOWN,    2'd1, 1'b0, 1'b0, CF * FRAME_CYC);
      push(GS_PLAYING,      2'd0, 1'b1, 1'b0, CF * FRAME_CYC);
   endtask

   initial begin
      rst          = 1'b1;
      btn_fire_raw = 1'b0;
      player_dead  = 1'b0;
      repeat (4) @(negedge pixel_clk);
      check_reset_outputs("reset");
      rst    = 1'b0;
      mon_en = 1'b1;
      frames(2);

      // One-frame glitch must never be accepted
      btn_fire_raw = 1'b1;
      next_frame();
      btn_fire_raw = 1'b0;
      frames(4);
      check("glitch_state", {30'b0, game_state}, 32'd0);

      // Held press starts the countdown; held button must not cause extra transitions
      expect_start_sequence();
      btn_fire_raw = 1'b1;
      frames(3);
      wait_state("reach_playing", GS_PLAYING, 20);
      frames(3);

      // Button held into GAME_OVER: hold expiry alone must not leave, re-press required
      push(GS_GAME_OVER, 2'd0, 1'b0, 1'b0, -1);
      pulse_dead();
      frames(GH + 5);
      pulse_dead();
      frames(2);
      check("held_after_hold", {30'b0, game_state}, {30'b0, GS_GAME_OVER});
      btn_fire_raw = 1'b0;
      frames(3);
      push(GS_GAME_OVER,    2'd0, 1'b0, 1'b1, -1);
      push(GS_START_SCREEN, 2'd0, 1'b0, 1'b0, 1);
      btn_fire_raw = 1'b1;
      frames(3);
      btn_fire_raw = 1'b0;
      frames(3);
      check("rearm_start", {30'b0, game_state}, {30'b0, GS_START_SCREEN});

      // Early press in GAME_OVER is exported but ignored; later press returns to start
      expect_start_sequence();
      btn_fire_raw = 1'b1;
      frames(3);
      btn_fire_raw = 1'b0;
      wait_state("reach_playing_2", GS_PLAYING, 20);
      push(GS_GAME_OVER, 2'd0, 1'b0, 1'b0, -1);
      pulse_dead();
      frames(8);
      push(GS_GAME_OVER, 2'd0, 1'b0, 1'b1, -1);
      btn_fire_raw = 1'b1;
      frames(3);
      btn_fire_raw = 1'b0;
      frames(GH - 5);
      check("early_press_ignored", {30'b0, game_state}, {30'b0, GS_GAME_OVER});
      push(GS_GAME_OVER,    2'd0, 1'b0, 1'b1, -1);
      push(GS_START_SCREEN, 2'd0, 1'b0, 1'b0, 1);
      btn_fire_raw = 1'b1;
      frames(3);
      btn_fire_raw = 1'b0;
      frames(3);

      // Reset in COUNTDOWN at digit 2: back to start, no game_start ever follows
      push(GS_START_SCREEN, 2'd0, 1'b0, 1'b1, -1);
      push(GS_COUNTDOWN,    2'd3, 1'b0, 1'b0, 1);
      push(GS_COUNTDOWN,    2'd2, 1'b0, 1'b0, -1);
      push(GS_START_SCREEN, 2'd0, 1'b0, 1'b0, -1);
      btn_fire_raw = 1'b1;
      frames(3);
      wait_digit("reach_digit2", 2'd2, 10);
      btn_fire_raw = 1'b0;
      repeat (3) @(negedge pixel_clk);
      rst = 1'b1;
      @(negedge pixel_clk);
      check_reset_outputs("mid_reset");
      rst = 1'b0;
      frames(20);
      check("post_reset_state", {30'b0, game_state}, 32'd0);

      check("scoreboard_drained", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
